data_merge_arbiter: RTL and testbench
=====================================

DATA_MERGE_ARBITER -- requirements
Module: data_merge_arbiter

Interface
REQ-001 Parameter: DW, default 128, data width of all streams in bits.
REQ-002 clk  input  1  single clock; all logic rising-edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 PACKET_SIZE  input  16  beats per packet; sampled at grant start.
REQ-005 PP_GROUP  input  8  packets per group; sampled at grant start.
REQ-006 axis_in1_tdata / axis_in1_tvalid / axis_in1_tready  input/input/output  DW/1/1  requester 1 stream.
REQ-007 axis_in2_tdata / axis_in2_tvalid / axis_in2_tready  input/input/output  DW/1/1  requester 2 stream.
REQ-008 axis_out_tdata / axis_out_tvalid / axis_out_tready  output/output/input  DW/1/1  merged stream.
REQ-009 axis_out_tlast  output  1  high on last beat of each packet.
REQ-010 grant  output  2  one-hot owner: 01 = in1, 10 = in2, 00 = none.
REQ-011 group_done  output  1  one-cycle pulse when the final beat of a group is accepted from the input.

Function
REQ-012 The block SHALL implement FSM states ARB, GRANT1, GRANT2.
REQ-013 ARB: if only one input tvalid is high, the block SHALL grant it; if both are high, it SHALL grant the input indicated by the round-robin pointer; if neither, it SHALL stay in ARB.
REQ-014 Round-robin pointer SHALL reset to in1 and SHALL point to the other input after each completed group.
REQ-015 On ARB->GRANTx, the block SHALL latch pkt_len = max(PACKET_SIZE,1) and grp_len = max(PP_GROUP,1); config changes mid-group SHALL be ignored.
REQ-016 Only the granted input's tready SHALL be high, equal to (!axis_out_tvalid || axis_out_tready); the non-granted tready and both tready in ARB SHALL be 0.
REQ-017 Accepted beat = granted tvalid && tready; on accept, tdata SHALL be registered to axis_out_tdata and axis_out_tvalid set to 1 on the next cycle (latency 1).
REQ-018 axis_out_tvalid SHALL clear after axis_out_tready when no new beat is accepted the same cycle; simultaneous accept and drain SHALL keep tvalid high with new data.
REQ-019 axis_out_tdata/tlast SHALL hold stable while axis_out_tvalid && !axis_out_tready.
REQ-020 Beat counter (16-bit) SHALL increment per accepted beat and wrap to 0 on beat pkt_len-1, incrementing the 8-bit packet counter.
REQ-021 axis_out_tlast SHALL be registered with the beat accepted when beat counter = pkt_len-1.
REQ-022 On accepting beat pkt_len-1 of packet grp_len-1, the block SHALL pulse group_done, clear both counters, toggle the pointer, and return to ARB the next cycle.
REQ-023 Granted input deasserting tvalid mid-group SHALL NOT release the grant; the block SHALL wait in GRANTx.
REQ-024 grant SHALL reflect the FSM state combinationally (01 in GRANT1, 10 in GRANT2, 00 in ARB).
REQ-025 Beats from the non-granted input SHALL never reach the output.

Reset
REQ-026 While reset is high at a clock edge: state = ARB, pointer = in1, counters = 0, axis_out_tvalid = 0, axis_out_tlast = 0, axis_out_tdata = 0, group_done = 0.
REQ-027 Reset asserted mid-group SHALL discard the partial group and any pending output beat; no output beat SHALL be presented on the cycle after reset.
REQ-028 axis_in1_tready and axis_in2_tready SHALL be 0 during reset.

Verification
REQ-029 PACKET_SIZE=4, PP_GROUP=2, only in1 valid, out_tready=1 -> grant=01, 8 beats out, tlast on beats 4 and 8, group_done once, then ARB.
REQ-030 Both inputs always valid, PACKET_SIZE=3, PP_GROUP=1 -> groups alternate in1, in2, in1; data order per source preserved; no interleaving within a group.
REQ-031 out_tready toggled randomly, 1000 beats -> no lost/duplicated beats; tdata stable while stalled.
REQ-032 PACKET_SIZE=0, PP_GROUP=0 -> treated as 1: every beat has tlast=1 and group_done pulses each beat.
REQ-033 in1 drops tvalid for 5 cycles mid-group while in2 valid -> grant stays 01, group completes on in1.
REQ-034 Reset asserted after 3 of 8 beats -> next cycle out_tvalid=0, grant=00; new group restarts beat count at 0.

Source files
------------

// File: rtl/data_merge_arbiter.sv
// data_merge_arbiter
//   Merges two AXI-Stream requesters onto one output stream. Ownership is
//   granted per group of packets (PP_GROUP packets of PACKET_SIZE beats);
//   contention is resolved by a round-robin pointer that flips after every
//   completed group. The output is a single registered stage.
//
// Ports
//   clk, reset                  clock, synchronous active-high reset
//   PACKET_SIZE, PP_GROUP       beats per packet / packets per group
//                               (0 treated as 1, sampled when a grant starts)
//   axis_in1_*, axis_in2_*      requester streams (tdata/tvalid in, tready out)
//   axis_out_*                  merged stream (tdata/tvalid/tlast out, tready in)
//   grant                       one-hot owner: 01 in1, 10 in2, 00 arbitrating
//   group_done                  one-cycle pulse after a group's final beat
//                               has been accepted from the input
module data_merge_arbiter #(
    parameter int DW = 128
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [15:0]   PACKET_SIZE,
    input  logic [7:0]    PP_GROUP,
    input  logic [DW-1:0] axis_in1_tdata,
    input  logic          axis_in1_tvalid,
    output logic          axis_in1_tready,
    input  logic [DW-1:0] axis_in2_tdata,
    input  logic          axis_in2_tvalid,
    output logic          axis_in2_tready,
    output logic [DW-1:0] axis_out_tdata,
    output logic          axis_out_tvalid,
    input  logic          axis_out_tready,
    output logic          axis_out_tlast,
    output logic [1:0]    grant,
    output logic          group_done
);

    typedef enum logic [1:0] {
        ARB    = 2'd0,
        GRANT1 = 2'd1,
        GRANT2 = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic          ptr_q, ptr_d;            // 0: in1 wins a tie, 1: in2 wins
    logic [15:0]   pkt_len_q, pkt_len_d;
    logic [7:0]    grp_len_q, grp_len_d;
    logic [15:0]   beat_q, beat_d;
    logic [7:0]    pkt_q, pkt_d;
    logic          out_vld_q, out_vld_d;
    logic          out_last_q, out_last_d;
    logic [DW-1:0] out_data_q, out_data_d;
    logic          gd_q, gd_d;

    logic          out_free;
    logic          accept1, accept2, accept;
    logic          last_beat, last_pkt;
    logic [DW-1:0] sel_data;

    // The output register can take a beat when empty or draining this cycle.
    // tready is gated by reset so no handshake completes while in reset.
    assign out_free        = !out_vld_q || axis_out_tready;
    assign axis_in1_tready = (state_q == GRANT1) && out_free && !reset;
    assign axis_in2_tready = (state_q == GRANT2) && out_free && !reset;

    assign accept1   = axis_in1_tvalid && axis_in1_tready;
    assign accept2   = axis_in2_tvalid && axis_in2_tready;
    assign accept    = accept1 || accept2;
    assign sel_data  = accept2 ? axis_in2_tdata : axis_in1_tdata;

    assign last_beat = (beat_q == pkt_len_q - 16'd1);
    assign last_pkt  = (pkt_q == grp_len_q - 8'd1);

    assign axis_out_tdata  = out_data_q;
    assign axis_out_tvalid = out_vld_q;
    assign axis_out_tlast  = out_last_q;
    assign group_done      = gd_q;

    always_comb begin
        grant = 2'b00;
        case (state_q)
            GRANT1:  grant = 2'b01;
            GRANT2:  grant = 2'b10;
            default: grant = 2'b00;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        pkt_len_d  = pkt_len_q;
        grp_len_d  = grp_len_q;
        beat_d     = beat_q;
        pkt_d      = pkt_q;
        gd_d       = 1'b0;
        out_vld_d  = out_vld_q;
        out_last_d = out_last_q;
        out_data_d = out_data_q;

        case (state_q)
            ARB: begin
                // Tie goes to the pointer; a lone requester always wins.
                if (axis_in1_tvalid && (!axis_in2_tvalid || !ptr_q)) begin
                    state_d = GRANT1;
                end else if (axis_in2_tvalid) begin
                    state_d = GRANT2;
                end
                if (axis_in1_tvalid || axis_in2_tvalid) begin
                    pkt_len_d = (PACKET_SIZE == 16'd0) ? 16'd1 : PACKET_SIZE;
                    grp_len_d = (PP_GROUP == 8'd0) ? 8'd1 : PP_GROUP;
                    beat_d    = 16'd0;
                    pkt_d     = 8'd0;
                end
            end
            GRANT1, GRANT2: begin
                // A stalled owner keeps the grant; only group completion releases it.
                if (accept) begin
                    if (last_beat) begin
                        beat_d = 16'd0;
                        if (last_pkt) begin
                            pkt_d   = 8'd0;
                            gd_d    = 1'b1;
                            ptr_d   = ~ptr_q;
                            state_d = ARB;
                        end else begin
                            pkt_d = pkt_q + 8'd1;
                        end
                    end else begin
                        beat_d = beat_q + 16'd1;
                    end
                end
            end
            default: state_d = ARB;
        endcase

        // Accept and drain in the same cycle keeps tvalid high with new data.
        if (accept) begin
            out_data_d = sel_data;
            out_last_d = last_beat;
            out_vld_d  = 1'b1;
        end else if (axis_out_tready) begin
            out_vld_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ARB;
            ptr_q      <= 1'b0;
            pkt_len_q  <= 16'd1;
            grp_len_q  <= 8'd1;
            beat_q     <= 16'd0;
            pkt_q      <= 8'd0;
            gd_q       <= 1'b0;
            out_vld_q  <= 1'b0;
            out_last_q <= 1'b0;
            out_data_q <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            pkt_len_q  <= pkt_len_d;
            grp_len_q  <= grp_len_d;
            beat_q     <= beat_d;
            pkt_q      <= pkt_d;
            gd_q       <= gd_d;
            out_vld_q  <= out_vld_d;
            out_last_q <= out_last_d;
            out_data_q <= out_data_d;
        end
    end

endmodule

// File: tb/tb_data_merge_arbiter.sv
// Testbench for data_merge_arbiter: directed scenarios feed two sources whose
// beats carry {source id, sequence index}; the expected output order is queued
// when each scenario is set up and a free-running monitor pops and compares
// every output handshake, counts group_done pulses and checks stall stability.
module tb_data_merge_arbiter;

    localparam int DW = 32;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          l;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset;
    logic [15:0]   PACKET_SIZE;
    logic [7:0]    PP_GROUP;
    logic [DW-1:0] in1_d, in2_d;
    logic          in1_v, in2_v, in1_r, in2_r;
    logic [DW-1:0] out_d;
    logic          out_v, out_r, out_l;
    logic [1:0]    grant;
    logic          gd;

    exp_t          sb[$];
    int            n_pass = 0;
    int            n_tot  = 0;
    int            gd_cnt = 0;

    logic [15:0]   idx1 = 16'd0, idx2 = 16'd0;
    int            rem1 = 0, rem2 = 0;
    logic          en1 = 1'b0, en2 = 1'b0, rnd_rdy = 1'b0;

    data_merge_arbiter #(.DW(DW)) dut (
        .clk             (clk),
        .reset           (reset),
        .PACKET_SIZE     (PACKET_SIZE),
        .PP_GROUP        (PP_GROUP),
        .axis_in1_tdata  (in1_d),
        .axis_in1_tvalid (in1_v),
        .axis_in1_tready (in1_r),
        .axis_in2_tdata  (in2_d),
        .axis_in2_tvalid (in2_v),
        .axis_in2_tready (in2_r),
        .axis_out_tdata  (out_d),
        .axis_out_tvalid (out_v),
        .axis_out_tready (out_r),
        .axis_out_tlast  (out_l),
        .grant           (grant),
        .group_done      (gd)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] mk(input logic [7:0] src, input logic [15:0] idx);
        return {src, 8'h00, idx};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    endtask

    task automatic push(input logic [7:0] src, input logic [15:0] base, input int n, input int ps);
        for (int k = 0; k < n; k++) begin
            exp_t e;
            e.d = mk(src, base + 16'(k));
            e.l = ((k % ps) == ps - 1);
            sb.push_back(e);
        end
    endtask

    task automatic drive();
        in1_v = en1 && (rem1 > 0);
        in2_v = en2 && (rem2 > 0);
        in1_d = mk(8'd1, idx1);
        in2_d = mk(8'd2, idx2);
    endtask

    // One clock: sample handshakes at the falling edge, update sources after the rising edge.
    task automatic tick();
        logic f1, f2;
        @(negedge clk);
        f1 = in1_v && in1_r;
        f2 = in2_v && in2_r;
        @(posedge clk);
        #1;
        if (f1) begin idx1 = idx1 + 16'd1; rem1--; end
        if (f2) begin idx2 = idx2 + 16'd1; rem2--; end
        out_r = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        drive();
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 6000 && sb.size() != 0; i++) tick();
        chk(name, 64'(sb.size()), 64'd0);
        for (int i = 0; i < 4; i++) tick();
    endtask

    task automatic do_reset();
        en1 = 1'b0; en2 = 1'b0; rem1 = 0; rem2 = 0; rnd_rdy = 1'b0;
        reset = 1'b1;
        drive();
        tick();
        tick();
        chk("rst_out_tvalid", 64'(out_v), 64'd0);
        chk("rst_grant", 64'(grant), 64'd0);
        chk("rst_in1_tready", 64'(in1_r), 64'd0);
        chk("rst_in2_tready", 64'(in2_r), 64'd0);
        chk("rst_group_done", 64'(gd), 64'd0);
        chk("rst_out_tlast", 64'(out_l), 64'd0);
        chk("rst_out_tdata", 64'(out_d), 64'd0);
        reset = 1'b0;
        tick();
    endtask

    // Monitor: compares every output handshake against the scoreboard.
    initial begin
        logic          stall;
        logic [DW-1:0] held_d;
        logic          held_l;
        stall = 1'b0;
        held_d = '0;
        held_l = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                stall = 1'b0;
            end else begin
                if (gd) gd_cnt++;
                if (stall) chk("stall_stable", 64'({out_v, out_l, out_d}), 64'({1'b1, held_l, held_d}));
                if (out_v && out_r) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_beat", 64'(out_d), 64'hFFFF_FFFF_FFFF_FFFF);
                    end else begin
                        exp_t e;
                        e = sb.pop_front();
                        chk("out_beat", 64'({out_l, out_d}), 64'({e.l, e.d}));
                    end
                end
                stall  = out_v && !out_r;
                held_d = out_d;
                held_l = out_l;
            end
        end
    end

    initial begin
        int g0;
        logic [15:0] b1, b2;
        reset = 1'b1; PACKET_SIZE = 16'd4; PP_GROUP = 8'd2; out_r = 1'b1;
        drive();
        do_reset();

        // Single requester, 2 packets of 4 beats.
        g0 = gd_cnt; b1 = idx1;
        PACKET_SIZE = 16'd4; PP_GROUP = 8'd2;
        push(8'd1, b1, 8, 4);
        en1 = 1'b1; rem1 = 8; drive();
        for (int i = 0; i < 20 && grant == 2'b00; i++) tick();
        chk("t1_grant", 64'(grant), 64'd1);
        drain("t1_drain");
        chk("t1_group_done", 64'(gd_cnt - g0), 64'd1);
        chk("t1_back_to_arb", 64'(grant), 64'd0);

        // Both always valid, groups of one 3-beat packet: in1, in2, in1.
        do_reset();
        g0 = gd_cnt; b1 = idx1; b2 = idx2;
        PACKET_SIZE = 16'd3; PP_GROUP = 8'd1;
        push(8'd1, b1, 3, 3);
        push(8'd2, b2, 3, 3);
        push(8'd1, b1 + 16'd3, 3, 3);
        en1 = 1'b1; en2 = 1'b1; rem1 = 6; rem2 = 3; drive();
        drain("t2_drain");
        chk("t2_group_done", 64'(gd_cnt - g0), 64'd3);

        // Random backpressure, 1000 beats, 5-beat packets, 3-packet groups.
        g0 = gd_cnt; b1 = idx1;
        PACKET_SIZE = 16'd5; PP_GROUP = 8'd3;
        push(8'd1, b1, 1000, 5);
        en1 = 1'b1; en2 = 1'b0; rem1 = 1000; rnd_rdy = 1'b1; drive();
        drain("t3_drain");
        chk("t3_group_done", 64'(gd_cnt - g0), 64'd66);
        rnd_rdy = 1'b0;

        // Zero sizes behave as 1: every beat is last and ends a group.
        do_reset();
        g0 = gd_cnt; b1 = idx1;
        PACKET_SIZE = 16'd0; PP_GROUP = 8'd0;
        push(8'd1, b1, 3, 1);
        en1 = 1'b1; rem1 = 3; drive();
        drain("t4_drain");
        chk("t4_group_done", 64'(gd_cnt - g0), 64'd3);

        // Owner drops tvalid mid-group while the other requester waits.
        g0 = gd_cnt; b1 = idx1; b2 = idx2;
        PACKET_SIZE = 16'd2; PP_GROUP = 8'd2;
        push(8'd1, b1, 4, 2);
        push(8'd2, b2, 4, 2);
        en1 = 1'b1; rem1 = 4; drive();
        for (int i = 0; i < 20 && grant == 2'b00; i++) tick();
        chk("t5_grant_start", 64'(grant), 64'd1);
        en2 = 1'b1; rem2 = 4; drive();
        for (int i = 0; i < 20 && idx1 == b1; i++) tick();
        en1 = 1'b0; drive();
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t5_grant_hold", 64'(grant), 64'd1);
        end
        en1 = 1'b1; drive();
        drain("t5_drain");
        chk("t5_group_done", 64'(gd_cnt - g0), 64'd2);

        // Reset after 3 of 8 beats; the third beat is pending and must vanish.
        do_reset();
        b1 = idx1;
        PACKET_SIZE = 16'd4; PP_GROUP = 8'd2;
        push(8'd1, b1, 2, 4);
        en1 = 1'b1; rem1 = 3; drive();
        for (int i = 0; i < 50 && rem1 != 0; i++) tick();
        reset = 1'b1; en1 = 1'b0; drive();
        tick();
        chk("t6_out_tvalid_after_rst", 64'(out_v), 64'd0);
        chk("t6_grant_after_rst", 64'(grant), 64'd0);
        chk("t6_no_lost_beats", 64'(sb.size()), 64'd0);
        reset = 1'b0;
        tick();
        g0 = gd_cnt; b1 = idx1;
        PACKET_SIZE = 16'd4; PP_GROUP = 8'd1;
        push(8'd1, b1, 4, 4);
        en1 = 1'b1; rem1 = 4; drive();
        drain("t6_restart_drain");
        chk("t6_group_done", 64'(gd_cnt - g0), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
